tt_um_denishoornaert_ttihp_test: RTL and testbench
==================================================

TT_UM_DENISHOORNAERT_TTIHP_TEST -- requirements
Module: tt_um_denishoornaert_ttihp_test

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low, on ports clk and rst_n.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  design enable; when 0, all state holds.
REQ-005 ui_in  input  8  operand D for the current command.
REQ-006 uio_in  input  8  [3:0] opcode, [4] cmd_valid, [7:5] ignored.
REQ-007 uo_out  output  8  accumulator ACC.
REQ-008 uio_out  output  8  [7] N, [6] C, [5] Z, [4:0] constant 0.
REQ-009 uio_oe  output  8  constant 8'hE0: bits 7:5 are outputs, bits 4:0 are inputs.

Function
REQ-010 State SHALL be an 8-bit ACC, an 8-bit backup register B and a carry flag C.
REQ-011 A command SHALL execute on every rising clk edge with ena=1 and cmd_valid=1; otherwise ACC, B and C hold.
REQ-012 Latency SHALL be one cycle: results appear on uo_out and uio_out right after the executing edge; no handshake, no busy, a new command every cycle.
REQ-013 Opcodes (D=ui_in):
- 0 NOP: no change.
- 1 LOAD: ACC=D; C unchanged.
- 2 ADD: {C,ACC}=ACC+D.
- 3 ADC: {C,ACC}=ACC+D+C.
- 4 SUB: ACC=ACC-D; C=1 iff borrow (ACC<D unsigned).
- 5 SBB: ACC=ACC-D-C; C=1 iff borrow.
- 6 AND, 7 OR, 8 XOR: ACC=ACC op D; C=0.
- 9 NOT: ACC=~ACC; C=0.
- A ROL: rotate ACC left by D[2:0]; C=0.
- B ROR: rotate ACC right by D[2:0]; C=0.
- C SHR: logical shift ACC right by D[2:0], zero fill; C=0.
- D STORE: B=ACC; ACC and C unchanged.
- E SWAP: ACC and B exchanged in the same edge; C unchanged.
- F CLR: ACC=0, C=0; B unchanged.
REQ-014 Arithmetic SHALL be 8-bit modulo 256, with carry/borrow taken from bit 8 of a 9-bit result.
REQ-015 Shift/rotate amount 0 SHALL leave ACC unchanged and still clear C.
REQ-016 Z SHALL be (ACC==0) and N SHALL be ACC[7], both decoded combinationally from the registered ACC.
REQ-017 ui_in and uio_in[7:5] SHALL have no effect when cmd_valid=0.

Reset
REQ-018 When rst_n=0, ACC, B and C SHALL clear immediately: uo_out=0x00, uio_out=0x20 (Z=1), uio_oe=0xE0.
REQ-019 Reset SHALL override any command in flight; the first command executes on the first qualifying edge after rst_n rises.

Structure
REQ-020 A shared package alu_pkg SHALL hold the 4-bit opcode enum (NOP..CLR) and the UIO_OE constant 8'hE0.
REQ-021 A purely combinational sub-module tt_alu SHALL compute next ACC, next B and next C from (opcode, ACC, B, C, D).
REQ-022 The top level SHALL hold the registers, enable qualification and output mapping.

Verification
REQ-023 Reset: assert rst_n=0 mid-run with ACC=0x5A -> uo_out=0x00 and uio_out=0x20 with no clock edge.
REQ-024 Add/carry: LOAD 0xF0, ADD 0x20 -> ACC=0x10, C=1; then ADC 0x01 -> ACC=0x12, C=0.
REQ-025 Borrow: LOAD 0x05, SUB 0x06 -> ACC=0xFF, C=1, N=1; then SBB 0xFE -> ACC=0x00, C=0, Z=1.
REQ-026 Rotate/shift: LOAD 0x81, ROL 1 -> 0x03; ROR 2 -> 0xC0; SHR 7 -> 0x01; ROL 0 -> 0x01 with C=0.
REQ-027 Register ops: LOAD 0x11, STORE, LOAD 0x22, SWAP -> ACC=0x11 and B=0x22; SWAP again -> ACC=0x22.
REQ-028 Gating: with cmd_valid=0 or ena=0, drive LOAD 0x99 -> ACC unchanged; uio_oe stays 0xE0 throughout.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encoding and pad-direction constant for the accumulator ALU.
package alu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned SHAMT_W = 3;

    localparam logic [DATA_W-1:0] UIO_OE = 8'hE0;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_ADD   = 4'h2,
        OP_ADC   = 4'h3,
        OP_SUB   = 4'h4,
        OP_SBB   = 4'h5,
        OP_AND   = 4'h6,
        OP_OR    = 4'h7,
        OP_XOR   = 4'h8,
        OP_NOT   = 4'h9,
        OP_ROL   = 4'hA,
        OP_ROR   = 4'hB,
        OP_SHR   = 4'hC,
        OP_STORE = 4'hD,
        OP_SWAP  = 4'hE,
        OP_CLR   = 4'hF
    } opcode_e;

endpackage

// File: rtl/tt_alu.sv
// Combinational next-state logic for ACC, backup register B and carry C.
module tt_alu
    import alu_pkg::*;
(
    input  opcode_e           op,
    input  logic [DATA_W-1:0] acc,
    input  logic [DATA_W-1:0] b,
    input  logic              c,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] acc_nxt_c,
    output logic [DATA_W-1:0] b_nxt_c,
    output logic              c_nxt_c
);

    localparam int unsigned WIDE_W = DATA_W + 1;
    localparam int unsigned DBL_W  = 2 * DATA_W;

    logic [WIDE_W-1:0]  sum;
    logic [WIDE_W-1:0]  diff;
    logic [SHAMT_W-1:0] shamt;
    logic [DBL_W-1:0]   rol_w;
    logic [DBL_W-1:0]   ror_w;
    logic               cin;

    // Shared 9-bit adder/subtractor and rotate datapaths; bit 8 is carry/borrow.
    always_comb begin
        cin   = ((op == OP_ADC) || (op == OP_SBB)) ? c : 1'b0;
        sum   = WIDE_W'(acc) + WIDE_W'(d) + WIDE_W'(cin);
        diff  = WIDE_W'(acc) - WIDE_W'(d) - WIDE_W'(cin);
        shamt = d[SHAMT_W-1:0];
        rol_w = {acc, acc} << shamt;
        ror_w = {acc, acc} >> shamt;
    end

    // Opcode decode: pick next ACC/B/C, holding anything the opcode does not touch.
    always_comb begin
        acc_nxt_c = acc;
        b_nxt_c   = b;
        c_nxt_c   = c;
        unique case (op)
            OP_NOP:   ;
            OP_LOAD:  acc_nxt_c = d;
            OP_ADD,
            OP_ADC: begin
                acc_nxt_c = sum[DATA_W-1:0];
                c_nxt_c   = sum[DATA_W];
            end
            OP_SUB,
            OP_SBB: begin
                acc_nxt_c = diff[DATA_W-1:0];
                c_nxt_c   = diff[DATA_W];
            end
            OP_AND: begin
                acc_nxt_c = acc & d;
                c_nxt_c   = 1'b0;
            end
            OP_OR: begin
                acc_nxt_c = acc | d;
                c_nxt_c   = 1'b0;
            end
            OP_XOR: begin
                acc_nxt_c = acc ^ d;
                c_nxt_c   = 1'b0;
            end
            OP_NOT: begin
                acc_nxt_c = ~acc;
                c_nxt_c   = 1'b0;
            end
            OP_ROL: begin
                acc_nxt_c = rol_w[DBL_W-1:DATA_W];
                c_nxt_c   = 1'b0;
            end
            OP_ROR: begin
                acc_nxt_c = ror_w[DATA_W-1:0];
                c_nxt_c   = 1'b0;
            end
            OP_SHR: begin
                acc_nxt_c = acc >> shamt;
                c_nxt_c   = 1'b0;
            end
            OP_STORE: b_nxt_c = acc;
            OP_SWAP: begin
                acc_nxt_c = b;
                b_nxt_c   = acc;
            end
            OP_CLR: begin
                acc_nxt_c = '0;
                c_nxt_c   = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tt_um_denishoornaert_ttihp_test.sv
// Accumulator ALU tile: state registers, enable qualification and pad mapping.
module tt_um_denishoornaert_ttihp_test
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  ui_in,
    input  logic [7:0]  uio_in,
    output logic [7:0]  uo_out,
    output logic [7:0]  uio_out,
    output logic [7:0]  uio_oe
);

    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] b_q;
    logic              c_q;
    logic [DATA_W-1:0] acc_nxt;
    logic [DATA_W-1:0] b_nxt;
    logic              c_nxt;
    logic              cmd_fire;
    opcode_e           op;

    // uio_in[7:5] are reserved pad inputs with no function.
    logic              unused_uio;
    assign unused_uio = &{1'b0, uio_in[7:5]};

    assign op       = opcode_e'(uio_in[OP_W-1:0]);
    assign cmd_fire = ena & uio_in[4];

    tt_alu u_alu (
        .op        (op),
        .acc       (acc_q),
        .b         (b_q),
        .c         (c_q),
        .d         (ui_in),
        .acc_nxt_c (acc_nxt),
        .b_nxt_c   (b_nxt),
        .c_nxt_c   (c_nxt)
    );

    // Architectural state updates only on a qualified command edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            b_q   <= '0;
            c_q   <= 1'b0;
        end else if (cmd_fire) begin
            acc_q <= acc_nxt;
            b_q   <= b_nxt;
            c_q   <= c_nxt;
        end
    end

    // Flags are decoded from the registered ACC/C so they track reset instantly.
    assign uo_out  = acc_q;
    assign uio_out = {acc_q[DATA_W-1], c_q, (acc_q == '0), 5'b0};
    assign uio_oe  = UIO_OE;

endmodule

// File: tb/tb_tt_um_denishoornaert_ttihp_test.sv
// Directed self-checking bench for the accumulator ALU tile.
module tb_tt_um_denishoornaert_ttihp_test;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks;
    int n_fails;

    tt_um_denishoornaert_ttihp_test dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Expected pads for a given ACC/C, built from bit definitions.
    task automatic check_state(input string tag, input logic [7:0] acc, input logic c);
        logic [7:0] flags;
        flags = {acc[7], c, (acc == 8'h00), 5'b0};
        check({tag, ".acc"}, uo_out, acc);
        check({tag, ".flags"}, uio_out, flags);
        check({tag, ".oe"}, uio_oe, 8'hE0);
    endtask

    // Present a command before a rising edge and sample 1ns after it.
    task automatic cmd(input logic [3:0] op, input logic [7:0] d,
                       input logic valid = 1'b1, input logic en = 1'b1,
                       input logic [2:0] junk = 3'b000);
        @(negedge clk);
        ena    = en;
        ui_in  = d;
        uio_in = {junk, valid, op};
        @(posedge clk);
        #1;
        uio_in = 8'h00;
        ena    = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        #2;
        check_state("reset", 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Add / carry chain
        cmd(4'h1, 8'hF0); check_state("load_f0", 8'hF0, 1'b0);
        cmd(4'h2, 8'h20); check_state("add_20", 8'h10, 1'b1);
        cmd(4'h3, 8'h01); check_state("adc_01", 8'h12, 1'b0);

        // Borrow chain
        cmd(4'h1, 8'h05); check_state("load_05", 8'h05, 1'b0);
        cmd(4'h4, 8'h06); check_state("sub_06", 8'hFF, 1'b1);
        cmd(4'h5, 8'hFE); check_state("sbb_fe", 8'h00, 1'b0);

        // Rotates and shift
        cmd(4'h1, 8'h81); check_state("load_81", 8'h81, 1'b0);
        cmd(4'hA, 8'h01); check_state("rol_1", 8'h03, 1'b0);
        cmd(4'hB, 8'h02); check_state("ror_2", 8'hC0, 1'b0);
        cmd(4'hC, 8'h07); check_state("shr_7", 8'h01, 1'b0);
        cmd(4'hA, 8'h00); check_state("rol_0", 8'h01, 1'b0);

        // Carry preserved by NOP/LOAD, cleared by zero-amount rotate
        cmd(4'h1, 8'hFF); check_state("load_ff", 8'hFF, 1'b0);
        cmd(4'h2, 8'h01); check_state("add_wrap", 8'h00, 1'b1);
        cmd(4'h0, 8'h77); check_state("nop", 8'h00, 1'b1);
        cmd(4'h1, 8'h80); check_state("load_keep_c", 8'h80, 1'b1);
        cmd(4'hB, 8'hF8); check_state("ror_0_clr_c", 8'h80, 1'b0);
        cmd(4'h2, 8'h80); check_state("add_c_again", 8'h00, 1'b1);
        cmd(4'hF, 8'h00); check_state("clr", 8'h00, 1'b0);

        // Logic ops
        cmd(4'h1, 8'h3C); check_state("load_3c", 8'h3C, 1'b0);
        cmd(4'h6, 8'h0F); check_state("and_0f", 8'h0C, 1'b0);
        cmd(4'h7, 8'h30); check_state("or_30", 8'h3C, 1'b0);
        cmd(4'h8, 8'hFF); check_state("xor_ff", 8'hC3, 1'b0);
        cmd(4'h9, 8'h00); check_state("not", 8'h3C, 1'b0);

        // Register ops
        cmd(4'h1, 8'h11); check_state("load_11", 8'h11, 1'b0);
        cmd(4'hD, 8'h00); check_state("store", 8'h11, 1'b0);
        cmd(4'h1, 8'h22); check_state("load_22", 8'h22, 1'b0);
        cmd(4'hE, 8'h00); check_state("swap1", 8'h11, 1'b0);
        cmd(4'hE, 8'h00); check_state("swap2", 8'h22, 1'b0);

        // Gating: no valid, or no enable
        cmd(4'h1, 8'h99, 1'b0, 1'b1, 3'b111); check_state("gate_valid", 8'h22, 1'b0);
        cmd(4'h1, 8'h99, 1'b1, 1'b0, 3'b101); check_state("gate_ena", 8'h22, 1'b0);
        cmd(4'h1, 8'h99, 1'b1, 1'b1, 3'b111); check_state("junk_hi_ok", 8'h99, 1'b0);

        // Asynchronous reset mid-run, away from any edge
        cmd(4'h1, 8'h5A); check_state("load_5a", 8'h5A, 1'b0);
        @(negedge clk);
        #2;
        uio_in = {3'b000, 1'b1, 4'h1};
        ui_in  = 8'h77;
        rst_n  = 1'b0;
        #1;
        check_state("async_rst", 8'h00, 1'b0);
        @(posedge clk);
        #1;
        check_state("rst_hold", 8'h00, 1'b0);
        @(negedge clk);
        rst_n  = 1'b1;
        uio_in = 8'h00;
        cmd(4'h1, 8'h01); check_state("post_rst_load", 8'h01, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
